dmem_responder: RTL and testbench

Memory-side responder for the processor's data-memory port. It replaces the zero-latency `dmem` with a multi-cycle, handshaked slave. Each request is accepted, held for a configurable number of wait states, and then answered with read data and an error flag. It sits between the core's load/store interface and a word-addressed RAM array, and lets the core and bench exercise stall handling.

---
 rtl/dmem_resp_pkg.sv | 8 +
 rtl/dmem_resp_ram.sv | 27 ++
 rtl/dmem_responder.sv | 85 ++++++++
 tb/tb_dmem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: shared state type, counter width and address error rule for dmem_responder
package dmem_resp_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} resp_state_t;
  localparam int CNT_W = 4;
  function automatic logic addr_err(input logic [31:0] addr, input int depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= unsigned'(depth));
  endfunction
endpackage

// File: rtl/dmem_resp_ram.sv
// dmem_resp_ram: word array, synchronous write, combinational read; byte strobes with DMEM_RESP_STROBE_EN
module dmem_resp_ram #(
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
`ifdef DMEM_RESP_STROBE_EN
  input  logic [3:0]    be,
`endif
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  assign rdata = mem[addr];
`ifdef DMEM_RESP_STROBE_EN
  // Write only the enabled byte lanes
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
`else
  // Full-word write
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
`endif
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked multi-cycle data-memory slave; DMEM_RESP_STROBE_EN adds req_be byte strobes
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_RESP_STROBE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  resp_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [31:0] ram_rdata, load_data, data_q;
  logic err, err_q, accept;
  assign accept = req_valid && (state == S_IDLE);
  assign err = addr_err(req_addr, DEPTH);
  assign load_data = (err || req_we) ? '0 : ram_rdata;
  dmem_resp_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (accept && req_we && !err),
    .addr  (req_addr[AW+1:2]),
    .wdata (req_wdata),
`ifdef DMEM_RESP_STROBE_EN
    .be    (req_be),
`endif
    .rdata (ram_rdata)
  );
  // Accept in IDLE, count wait states, then hold the response until it is taken;
  // the captured result stays hidden in data_q/err_q so outputs read 0 outside RESP
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          data_q <= load_data;
          err_q <= err;
          if (LATENCY > 1) begin
            state <= S_WAIT;
            cnt <= CNT_W'(LATENCY - 2);
          end else begin
            state <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
            resp_err <= err;
          end
        end
        S_WAIT: if (cnt == '0) begin
          state <= S_RESP;
          resp_valid <= 1'b1;
          resp_rdata <= data_q;
          resp_err <= err_q;
        end else cnt <= cnt - 1'b1;
        S_RESP: if (resp_ready) begin
          state <= S_IDLE;
          req_ready <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at LATENCY 2 and LATENCY 1
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_be = 4'hF;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic req_valid1 = 1'b0, req_we1 = 1'b0, resp_ready1 = 1'b1;
  logic [31:0] req_addr1 = '0, req_wdata1 = '0;
  logic [3:0] req_be1 = 4'hF;
  logic req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_RESP_STROBE_EN
    .req_be(req_be),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we1), .req_addr(req_addr1), .req_wdata(req_wdata1),
`ifdef DMEM_RESP_STROBE_EN
    .req_be(req_be1),
`endif
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  // One full transaction on u_dut; lat counts edges from acceptance (1) to resp_valid seen
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                     output logic [31:0] rd, output logic e, output int lat);
    resp_ready = 1'b1;
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wdata;
    req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    e = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    tests++; if (req_ready1 !== 1'b1 || resp_valid1 !== 1'b0) begin fails++; $display("FAIL reset_dut1: got ready %b valid %b want 1 0", req_ready1, resp_valid1); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic e; int lat;
    txn(1'b1, 32'h64, 32'h7, 4'hF, rd, e, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL store_latency: got %0d want 2", lat); end
    tests++; if (e !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL store_resp: got err %b data %h want 0 0", e, rd); end
    tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin fails++; $display("FAIL store_release: got ready %b valid %b want 1 0", req_ready, resp_valid); end
    txn(1'b0, 32'h64, 32'h0, 4'hF, rd, e, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL load_latency: got %0d want 2", lat); end
    tests++; if (rd !== 32'h7) begin fails++; $display("FAIL load_data: got %h want 00000007", rd); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL load_err: got %b want 0", e); end
  endtask

  // LATENCY=1 with req_valid held and resp_ready tied high: store, store, load, load
  task automatic test_lat1_back_to_back;
    logic [31:0] a [4];
    logic [31:0] d [4];
    logic w [4];
    logic [31:0] rd [4];
    logic vh [12];
    int acc [4];
    int k = 0;
    int n = 0;
    a = '{32'h60, 32'h64, 32'h60, 32'h64};
    d = '{32'hA5A50060, 32'h5A5A0064, 32'h0, 32'h0};
    w = '{1'b1, 1'b1, 1'b0, 1'b0};
    acc = '{-1, -1, -1, -1};
    rd = '{32'hX, 32'hX, 32'hX, 32'hX};
    resp_ready1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (req_ready1) begin
        if (k < 4) begin
          req_valid1 = 1'b1;
          req_we1 = w[k];
          req_addr1 = a[k];
          req_wdata1 = d[k];
          acc[k] = c;
          k++;
        end else req_valid1 = 1'b0;
      end
      @(posedge clk); #1;
      vh[c] = resp_valid1;
      if (resp_valid1 && n < 4) rd[n] = resp_rdata1;
      if (resp_valid1) n++;
    end
    req_valid1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++; if (acc[i] !== 2 * i) begin fails++; $display("FAIL lat1_accept_%0d: got cycle %0d want %0d", i, acc[i], 2 * i); end
    end
    for (int c = 0; c < 12; c++) begin
      tests++; if (vh[c] !== (c < 8 && c % 2 == 0)) begin fails++; $display("FAIL lat1_valid_cycle_%0d: got %b want %b", c, vh[c], (c < 8 && c % 2 == 0)); end
    end
    tests++; if (rd[2] !== 32'hA5A50060) begin fails++; $display("FAIL lat1_load_60: got %h want a5a50060", rd[2]); end
    tests++; if (rd[3] !== 32'h5A5A0064) begin fails++; $display("FAIL lat1_load_64: got %h want 5a5a0064", rd[3]); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic e; int lat;
    txn(1'b1, 32'h20, 32'h12345678, 4'hF, rd, e, lat);
    resp_ready = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 32'h20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin fails++; $display("FAIL wait_outputs: got valid %b data %h want 0 0", resp_valid, resp_rdata); end
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++; if (lat !== 2) begin fails++; $display("FAIL bp_latency: got %0d want 2", lat); end
    for (int i = 0; i < 5; i++) begin
      req_valid = (i % 2) == 0;
      req_we = 1'b1;
      req_wdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h12345678 || req_ready !== 1'b0)
        begin fails++; $display("FAIL bp_hold_%0d: got valid %b data %h ready %b want 1 12345678 0", i, resp_valid, resp_rdata, req_ready); end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got valid %b ready %b want 0 1", resp_valid, req_ready); end
    txn(1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat);
    tests++; if (rd !== 32'h12345678) begin fails++; $display("FAIL bp_no_side_effect: got %h want 12345678", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic e; int lat;
    txn(1'b1, 32'h00, 32'hCAFEF00D, 4'hF, rd, e, lat);
    txn(1'b1, 32'h102, 32'hDEADBEEF, 4'hF, rd, e, lat);
    tests++; if (e !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL misaligned_store: got err %b data %h want 1 0", e, rd); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL misaligned_latency: got %0d want 2", lat); end
    txn(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, rd, e, lat);
    tests++; if (e !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL range_store: got err %b data %h want 1 0", e, rd); end
    txn(1'b0, 32'h01, 32'h0, 4'hF, rd, e, lat);
    tests++; if (e !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL misaligned_load: got err %b data %h want 1 0", e, rd); end
    txn(1'b0, 32'hFC, 32'h0, 4'hF, rd, e, lat);
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL last_word_load_err: got %b want 0", e); end
    txn(1'b0, 32'h00, 32'h0, 4'hF, rd, e, lat);
    tests++; if (rd !== 32'hCAFEF00D || e !== 1'b0) begin fails++; $display("FAIL error_no_write: got err %b data %h want 0 cafef00d", e, rd); end
  endtask

`ifdef DMEM_RESP_STROBE_EN
  task automatic test_strobe;
    logic [31:0] rd; logic e; int lat;
    txn(1'b1, 32'h08, 32'h11223344, 4'hF, rd, e, lat);
    txn(1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, rd, e, lat);
    txn(1'b0, 32'h08, 32'h0, 4'hF, rd, e, lat);
    tests++; if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL strobe_merge: got %h want 11bb33dd", rd); end
    txn(1'b1, 32'h08, 32'h99999999, 4'b0000, rd, e, lat);
    tests++; if (e !== 1'b0 || lat !== 2) begin fails++; $display("FAIL strobe_noop_resp: got err %b lat %0d want 0 2", e, lat); end
    txn(1'b0, 32'h08, 32'h0, 4'hF, rd, e, lat);
    tests++; if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL strobe_noop_data: got %h want 11bb33dd", rd); end
  endtask
`endif

  task automatic test_reset_mid;
    logic [31:0] rd; logic e; int lat;
    resp_ready = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 32'h10;
    req_wdata = 32'h5;
    req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #2;
    tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL async_reset: got valid %b ready %b want 0 1", resp_valid, req_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL abandoned_resp_%0d: got %b want 0", i, resp_valid); end
    end
    txn(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
    tests++; if (rd !== 32'h5 || e !== 1'b0) begin fails++; $display("FAIL committed_store: got err %b data %h want 0 00000005", e, rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_lat1_back_to_back();
    test_backpressure();
    test_errors();
`ifdef DMEM_RESP_STROBE_EN
    test_strobe();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
